// File: rtl/bo_dieu_khien_chia_xung_if.sv
// Configuration port of the clock-divider controller: valid/ready handshake
// carrying the half-period terminal count and the burst pulse count.
interface bo_dieu_khien_chia_xung_if #(
    parameter int unsigned CNT_W   = 25,
    parameter int unsigned PULSE_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_div;
    logic [PULSE_W-1:0] cfg_pulses;

    // Control logic offering a new divide setting
    modport master (
        output cfg_valid,
        output cfg_div,
        output cfg_pulses,
        input  cfg_ready
    );

    // Divider controller accepting the setting
    modport slave (
        input  cfg_valid,
        input  cfg_div,
        input  cfg_pulses,
        output cfg_ready
    );
endinterface

// File: rtl/bo_dieu_khien_chia_xung.sv
// Programmable clock-divider controller. Produces a registered divided square
// wave (clk_out) and a one-cycle tick on every toggle, running continuously or
// for a burst of N full periods. Settings written while running are held in a
// shadow register and take effect only on a half-period boundary.
module bo_dieu_khien_chia_xung #(
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned DEFAULT_DIV = 24999999,
    parameter int unsigned PULSE_W     = 8
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic                         en,
    bo_dieu_khien_chia_xung_if.slave     cfg,
    output logic                         clk_out,
    output logic                         tick,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   div_reg;
    logic [CNT_W-1:0]   div_shadow;
    logic [PULSE_W-1:0] pulse_reg;
    logic [PULSE_W-1:0] pulse_shadow;
    logic [PULSE_W-1:0] rise_cnt;
    logic               pend;

    logic               xfer;
    logic               at_toggle;
    logic               burst_end;

    assign cfg.cfg_ready = !pend;
    assign busy          = (state == RUN);

    // Handshake and boundary decode from the current register state
    always_comb begin
        xfer      = cfg.cfg_valid && !pend;
        at_toggle = (cnt == div_reg);
        burst_end = at_toggle && clk_out && (pulse_reg != '0) && (rise_cnt == pulse_reg);
    end

    // Controller state, half-period counter, config registers and outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            div_reg      <= CNT_W'(DEFAULT_DIV);
            div_shadow   <= '0;
            pulse_reg    <= '0;
            pulse_shadow <= '0;
            rise_cnt     <= '0;
            pend         <= 1'b0;
            clk_out      <= 1'b0;
            tick         <= 1'b0;
            done         <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (xfer) begin
                        div_reg   <= cfg.cfg_div;
                        pulse_reg <= cfg.cfg_pulses;
                    end
                    if (en) begin
                        state    <= RUN;
                        clk_out  <= 1'b0;
                        rise_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!en && !clk_out) begin
                        // Stop in the low phase: leave at once, no toggle, no tick.
                        // Any setting (pending or offered now) lands directly,
                        // since IDLE must never be left with pend set.
                        state <= IDLE;
                        cnt   <= '0;
                        if (pend) begin
                            div_reg   <= div_shadow;
                            pulse_reg <= pulse_shadow;
                        end else if (xfer) begin
                            div_reg   <= cfg.cfg_div;
                            pulse_reg <= cfg.cfg_pulses;
                        end
                        pend <= 1'b0;
                    end else if (at_toggle) begin
                        cnt     <= '0;
                        clk_out <= ~clk_out;
                        tick    <= 1'b1;
                        if (!clk_out) begin
                            rise_cnt <= rise_cnt + 1'b1;
                        end
                        if (clk_out && (burst_end || !en)) begin
                            // Falling toggle ends the run (burst complete or stop request)
                            state <= IDLE;
                            done  <= burst_end;
                            if (pend) begin
                                div_reg   <= div_shadow;
                                pulse_reg <= pulse_shadow;
                            end else if (xfer) begin
                                div_reg   <= cfg.cfg_div;
                                pulse_reg <= cfg.cfg_pulses;
                            end
                            pend <= 1'b0;
                        end else if (pend) begin
                            // Boundary: adopt the shadow; burst counting restarts
                            div_reg   <= div_shadow;
                            pulse_reg <= pulse_shadow;
                            pend      <= 1'b0;
                            rise_cnt  <= '0;
                        end else if (xfer) begin
                            // Offered on a boundary: deferred to the following one
                            div_shadow   <= cfg.cfg_div;
                            pulse_shadow <= cfg.cfg_pulses;
                            pend         <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (xfer) begin
                            div_shadow   <= cfg.cfg_div;
                            pulse_shadow <= cfg.cfg_pulses;
                            pend         <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bo_dieu_khien_chia_xung.sv
// Directed bench for the clock-divider controller. Stimulus pushes the
// expected tick events (cycle, clk_out after the toggle, done) into a queue;
// an independent monitor pops and compares on every observed tick.
module tb_bo_dieu_khien_chia_xung;

    logic        clk_in;
    logic        rst;
    logic        en;
    logic        clk_out;
    logic        tick;
    logic        busy;
    logic        done;

    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned t0;

    typedef struct {
        int unsigned cyc;
        logic        clk;
        logic        dn;
    } exp_t;

    exp_t exp_q[$];

    bo_dieu_khien_chia_xung_if #(.CNT_W(25), .PULSE_W(8)) cfg_if ();

    bo_dieu_khien_chia_xung #(
        .CNT_W(25),
        .DEFAULT_DIV(24999999),
        .PULSE_W(8)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .en     (en),
        .cfg    (cfg_if),
        .clk_out(clk_out),
        .tick   (tick),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Monitor: every tick must match the next expected event
    always @(negedge clk_in) begin
        if (tick === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_tick: tick at cyc %0d clk_out=%0b done=%0b, required no tick",
                         cyc, clk_out, done);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.cyc || clk_out !== e.clk || done !== e.dn) begin
                    miscompares++;
                    $display("FAIL tick_event: got cyc %0d clk_out=%0b done=%0b, required cyc %0d clk_out=%0b done=%0b",
                             cyc, clk_out, done, e.cyc, e.clk, e.dn);
                end
            end
        end else if (done === 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL done_without_tick: done=1 at cyc %0d, required 0", cyc);
        end
    end

    task automatic expect_tick(input int unsigned c, input logic k, input logic d);
        exp_t e;
        e.cyc = c;
        e.clk = k;
        e.dn  = d;
        exp_q.push_back(e);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %0b, required %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chkw(input string name, input int unsigned act, input int unsigned exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %0d, required %0d", name, cyc, act, exp);
        end
    endtask

    task automatic wait_to(input int unsigned c);
        while (cyc < c) @(negedge clk_in);
    endtask

    // Offer a setting and hold it until accepted; returns on the negedge after transfer
    task automatic cfg_write(input logic [24:0] d, input logic [7:0] p);
        int unsigned n;
        n = 0;
        @(negedge clk_in);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_div    = d;
        cfg_if.cfg_pulses = p;
        while (cfg_if.cfg_ready !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (cfg_if.cfg_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL cfg_accept_timeout: cfg_ready=%0b after %0d cycles, required 1", cfg_if.cfg_ready, n);
        end
        @(negedge clk_in);
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        en                = 1'b0;
        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_div    = '0;
        cfg_if.cfg_pulses = '0;

        // Reset state
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk1("rst_clk_out", clk_out, 1'b0);
        chk1("rst_tick", tick, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_cfg_ready", cfg_if.cfg_ready, 1'b1);
        chkw("rst_div_reg", 32'(dut.div_reg), 24999999);
        rst = 1'b0;

        // Continuous div=3: toggles every 4 cycles, then stop in the low phase
        cfg_write(25'd3, 8'd0);
        en = 1'b1;
        t0 = cyc + 1;
        expect_tick(t0 + 4,  1'b1, 1'b0);
        expect_tick(t0 + 8,  1'b0, 1'b0);
        expect_tick(t0 + 12, 1'b1, 1'b0);
        expect_tick(t0 + 16, 1'b0, 1'b0);
        wait_to(t0 + 2);
        chk1("run_busy", busy, 1'b1);
        chk1("run_cfg_ready", cfg_if.cfg_ready, 1'b1);
        chk1("run_clk_low", clk_out, 1'b0);
        wait_to(t0 + 5);
        chk1("run_clk_high", clk_out, 1'b1);
        wait_to(t0 + 17);
        en = 1'b0;
        wait_to(t0 + 18);
        chk1("stop_low_busy", busy, 1'b0);
        chk1("stop_low_clk", clk_out, 1'b0);

        // Stop requested while high with cnt=1: two more high cycles, falling tick
        en = 1'b1;
        t0 = cyc + 1;
        expect_tick(t0 + 4, 1'b1, 1'b0);
        expect_tick(t0 + 8, 1'b0, 1'b0);
        wait_to(t0 + 5);
        en = 1'b0;
        wait_to(t0 + 7);
        chk1("stop_high_still_busy", busy, 1'b1);
        wait_to(t0 + 8);
        chk1("stop_high_busy", busy, 1'b0);

        // Burst div=1, 3 pulses: done on the 12th RUN edge
        cfg_write(25'd1, 8'd3);
        en = 1'b1;
        t0 = cyc + 1;
        expect_tick(t0 + 2,  1'b1, 1'b0);
        expect_tick(t0 + 4,  1'b0, 1'b0);
        expect_tick(t0 + 6,  1'b1, 1'b0);
        expect_tick(t0 + 8,  1'b0, 1'b0);
        expect_tick(t0 + 10, 1'b1, 1'b0);
        expect_tick(t0 + 12, 1'b0, 1'b1);
        wait_to(t0 + 11);
        chk1("burst_busy_before_end", busy, 1'b1);
        wait_to(t0 + 12);
        chk1("burst_end_busy", busy, 1'b0);
        en = 1'b0;
        wait_to(t0 + 13);
        chk1("burst_done_one_cycle", done, 1'b0);
        chk1("burst_idle_clk", clk_out, 1'b0);

        // Running div=3, write div=0 at cnt=1: applies at next toggle
        cfg_write(25'd3, 8'd0);
        en = 1'b1;
        t0 = cyc + 1;
        expect_tick(t0 + 4, 1'b1, 1'b0);
        expect_tick(t0 + 5, 1'b0, 1'b0);
        expect_tick(t0 + 6, 1'b1, 1'b0);
        expect_tick(t0 + 7, 1'b0, 1'b0);
        expect_tick(t0 + 8, 1'b1, 1'b0);
        expect_tick(t0 + 9, 1'b0, 1'b0);
        wait_to(t0 + 1);
        chk1("shadow_ready_before", cfg_if.cfg_ready, 1'b1);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_div    = 25'd0;
        cfg_if.cfg_pulses = 8'd0;
        wait_to(t0 + 2);
        cfg_if.cfg_valid = 1'b0;
        chk1("shadow_pend_ready", cfg_if.cfg_ready, 1'b0);
        wait_to(t0 + 3);
        chk1("shadow_still_pend", cfg_if.cfg_ready, 1'b0);
        wait_to(t0 + 4);
        chk1("shadow_applied_ready", cfg_if.cfg_ready, 1'b1);
        wait_to(t0 + 8);
        en = 1'b0;
        wait_to(t0 + 9);
        chk1("fast_stop_busy", busy, 1'b0);

        // div=0 continuous; transfer coincident with a toggle is deferred one toggle
        en = 1'b1;
        t0 = cyc + 1;
        expect_tick(t0 + 1, 1'b1, 1'b0);
        expect_tick(t0 + 2, 1'b0, 1'b0);
        expect_tick(t0 + 3, 1'b1, 1'b0);
        expect_tick(t0 + 6, 1'b0, 1'b0);
        expect_tick(t0 + 9, 1'b1, 1'b0);
        wait_to(t0 + 1);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_div    = 25'd2;
        cfg_if.cfg_pulses = 8'd4;
        wait_to(t0 + 2);
        cfg_if.cfg_valid = 1'b0;
        chk1("coinc_pend_ready", cfg_if.cfg_ready, 1'b0);
        wait_to(t0 + 3);
        chk1("coinc_applied_ready", cfg_if.cfg_ready, 1'b1);

        // Mid-burst reset with a pending setting
        wait_to(t0 + 9);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_div    = 25'd5;
        cfg_if.cfg_pulses = 8'd1;
        wait_to(t0 + 10);
        cfg_if.cfg_valid = 1'b0;
        chk1("midrst_pend_ready", cfg_if.cfg_ready, 1'b0);
        rst = 1'b1;
        en  = 1'b0;
        wait_to(t0 + 11);
        rst = 1'b0;
        chk1("midrst_clk_out", clk_out, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_cfg_ready", cfg_if.cfg_ready, 1'b1);
        chk1("midrst_done", done, 1'b0);
        chkw("midrst_div_reg", 32'(dut.div_reg), 24999999);
        chkw("midrst_pulse_reg", 32'(dut.pulse_reg), 0);
        wait_to(t0 + 16);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_ticks: %0d expected ticks not seen, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bo_dieu_khien_chia_xung.md
Name: bo_dieu_khien_chia_xung

Overview:
Programmable clock-divider controller. It generates a divided square wave and a one-cycle tick from clk_in, in either continuous or N-pulse burst mode. Divide settings load through a valid/ready config port. Changes made while running are applied glitch-free at the next half-period boundary. It sits between control logic (buttons/FSMs) and the blocks that consume slow enables (LED blink, counters, 7-seg scan).

Parameters:
CNT_W, 25, width of half-period counter and divide value
DEFAULT_DIV, 24999999, reset half-period terminal count (50 MHz -> 1 Hz)
PULSE_W, 8, width of burst pulse count

Ports:
clk_in  input  1  system clock; the only clock
rst  input  1  synchronous reset, active-high
en  input  1  run request (level)
cfg_valid  input  1  config offered
cfg_ready  output  1  config can be accepted
cfg_div  input  CNT_W  half-period terminal count; half-period = cfg_div+1 cycles
cfg_pulses  input  PULSE_W  0 = continuous, N>0 = burst of N full periods
clk_out  output  1  divided square wave (registered)
tick  output  1  one-cycle pulse on every clk_out toggle
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when a burst completes

Behaviour:
- All regs update on posedge clk_in. rst=1 overrides everything at that edge.
- Reset values:
  - state=IDLE, cnt=0, div_reg=DEFAULT_DIV, pulse_reg=0, pend=0, rise_cnt=0.
  - clk_out=0, tick=0, done=0, busy=0, cfg_ready=1.
- States: IDLE, RUN.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - cfg_ready = !pend.
  - In IDLE, a transfer writes div_reg/pulse_reg directly at that edge.
  - In RUN, a transfer writes shadow regs and sets pend=1, so cfg_ready=0.
  - Shadow is copied into div_reg/pulse_reg at the next toggle edge (the edge where cnt==div_reg). At that same edge pend=0 and rise_cnt=0.
  - A transfer on the same cycle as a toggle edge goes to shadow and applies at the following toggle. It never applies mid-half-period.
- IDLE -> RUN: on en=1. At that edge cnt=0, clk_out=0, rise_cnt=0.
- RUN, per cycle:
  - If cnt==div_reg: cnt<=0, clk_out<=~clk_out, tick<=1.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - First toggle occurs div_reg+1 edges after entry. Full period = 2*(div_reg+1) cycles.
  - div_reg=0 gives clk_in/2.
- Burst:
  - Each 0->1 toggle increments rise_cnt.
  - When pulse_reg!=0, on the 1->0 toggle with rise_cnt==pulse_reg: state<=IDLE, done<=1 for one cycle, cnt<=0. clk_out is 0 by that toggle.
  - tick is also 1 on that final edge.
- Stop (en=0 in RUN):
  - If clk_out=0, go to IDLE at the next edge with clk_out held 0 and no tick.
  - If clk_out=1, keep running until the 1->0 toggle, then go to IDLE. tick=1 on that edge, done=0.
  - Low phase is never truncated below a full half-period from a high phase.
- A pending shadow config is applied on any transition RUN->IDLE.
- cnt never exceeds div_reg, so no wrap is possible.
- Reset mid-run: reset values at the next edge. Shadow is discarded. No done pulse.

Test Plan:
1. rst, cfg_div=3, cfg_pulses=0, then en=1 -> clk_out rises 4 edges after entering RUN and has an 8-cycle period; tick every 4 cycles; busy=1; cfg_ready=1.
2. IDLE cfg_div=1, cfg_pulses=3, en=1 held -> exactly 3 clk_out high pulses of 2 cycles each; done=1 for one cycle on the 12th RUN edge; then busy=0, clk_out=0.
3. Running with div=3, write cfg_div=0 at cnt=1 -> cfg_ready=0 until the next toggle; from then clk_out toggles every cycle; cfg_ready returns to 1.
4. div=3 running: drop en while clk_out=1 with cnt=1 -> 2 more cycles high, then falling toggle and IDLE. Drop en while clk_out=0 -> IDLE next edge, clk_out stays 0, no tick.
5. cfg_div=0, cfg_pulses=0, en=1 -> clk_out=clk_in/2 and tick=1 every cycle. A config transfer coincident with a toggle is deferred to the next toggle.
6. Assert rst for 1 cycle mid-burst with pend=1 -> next edge: clk_out=0, busy=0, cfg_ready=1, div_reg=24999999, no done.
